// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command/address pin decoder: one-hot command vector, per-bank open-row
// tracking, burst column sequencing and sticky protocol-error reporting.
module ddr4_cmd_decoder #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 2,
  parameter int BANKSPERGROUP = 2,
  parameter int COLS          = 1024,
  parameter int BL            = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             halt,
  input  logic                             cke,
  input  logic                             cs_n,
  input  logic                             act_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [$clog2(BANKGROUPS)-1:0]    bg_in,
  input  logic [$clog2(BANKSPERGROUP)-1:0] ba_in,
  input  logic [ADDRWIDTH-1:0]             addr,
  output logic [18:0]                      commands,
  output logic [$clog2(BANKGROUPS)-1:0]    bg,
  output logic [$clog2(BANKSPERGROUP)-1:0] ba,
  output logic [ADDRWIDTH-1:0]             row,
  output logic [$clog2(COLS)-1:0]          column,
  output logic                             busy,
  output logic                             err,
  output logic [2:0]                       err_code
);

  localparam int BGW = $clog2(BANKGROUPS);
  localparam int BAW = $clog2(BANKSPERGROUP);
  localparam int CW  = $clog2(COLS);
  localparam int BLW = $clog2(BL);
  localparam int NB  = BANKGROUPS * BANKSPERGROUP;
  localparam int NBW = $clog2(NB);

  localparam logic [18:0] C_ACT = 19'h40000;
  localparam logic [18:0] C_CFG = 19'h10000;
  localparam logic [18:0] C_MRW = 19'h00400;
  localparam logic [18:0] C_PD  = 19'h00200;
  localparam logic [18:0] C_PDX = 19'h00100;
  localparam logic [18:0] C_PR  = 19'h00080;
  localparam logic [18:0] C_PRA = 19'h00040;
  localparam logic [18:0] C_RD  = 19'h00020;
  localparam logic [18:0] C_RDA = 19'h00010;
  localparam logic [18:0] C_REF = 19'h00008;
  localparam logic [18:0] C_SRF = 19'h00004;
  localparam logic [18:0] C_WR  = 19'h00002;
  localparam logic [18:0] C_WRA = 19'h00001;

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t                 state_r, state_s;
  logic [BLW-1:0]         beat_r, beat_s;
  logic [18:0]            commands_r, commands_s;
  logic [BGW-1:0]         bg_r, bg_s;
  logic [BAW-1:0]         ba_r, ba_s;
  logic [ADDRWIDTH-1:0]   row_r, row_s;
  logic [CW-1:0]          column_r, column_s;
  logic                   busy_r, busy_s;
  logic                   err_r;
  logic [2:0]             err_code_r;
  logic                   cke_q_r;
  logic [NB-1:0]          bank_open_r, bank_open_s;
  logic [ADDRWIDTH-1:0]   bank_row_r [NB];
  logic [NBW-1:0]         burst_bank_r, burst_bank_s;
  logic                   burst_auto_r, burst_auto_s;

  logic [NBW-1:0]         bank_idx_s;
  logic                   last_beat_s;
  logic [NB-1:0]          open_eff_s;
  logic                   pin_cmd_s;
  logic [18:0]            dec_cmd_s;
  logic [2:0]             dec_err_s;
  logic [2:0]             err_evt_s;
  logic                   act_we_s;

  // Pin decode against the bank state as it will be after any auto-precharge closing this edge
  always_comb begin
    bank_idx_s  = NBW'(bg_in) * NBW'(BANKSPERGROUP) + NBW'(ba_in);
    last_beat_s = (state_r == ST_BURST) && (beat_r == BLW'(BL - 1));
    open_eff_s  = bank_open_r;
    dec_cmd_s   = 19'h0;
    dec_err_s   = 3'd0;
    pin_cmd_s   = 1'b0;
    if (last_beat_s && burst_auto_r) begin
      open_eff_s[burst_bank_r] = 1'b0;
    end else begin
      open_eff_s = bank_open_r;
    end
    if (cs_n) begin
      pin_cmd_s = 1'b0;
    end else if (!act_n) begin
      pin_cmd_s = 1'b1;
      if (open_eff_s[bank_idx_s]) begin
        dec_err_s = 3'd2;
      end else begin
        dec_cmd_s = C_ACT;
      end
    end else begin
      pin_cmd_s = ({ras_n, cas_n, we_n} != 3'b111);
      case ({ras_n, cas_n, we_n})
        3'b000: dec_cmd_s = C_MRW;
        3'b001: begin
          if (|open_eff_s) begin
            dec_err_s = 3'd3;
          end else if (!cke && cke_q_r) begin
            dec_cmd_s = C_SRF;
          end else begin
            dec_cmd_s = C_REF;
          end
        end
        3'b010: dec_cmd_s = addr[10] ? C_PRA : C_PR;
        3'b100: begin
          if (!open_eff_s[bank_idx_s]) begin
            dec_err_s = 3'd1;
          end else begin
            dec_cmd_s = addr[10] ? C_WRA : C_WR;
          end
        end
        3'b101: begin
          if (!open_eff_s[bank_idx_s]) begin
            dec_err_s = 3'd1;
          end else begin
            dec_cmd_s = addr[10] ? C_RDA : C_RD;
          end
        end
        3'b110: dec_cmd_s = C_CFG;
        3'b011: dec_err_s = 3'd5;
        default: dec_cmd_s = 19'h0;
      endcase
    end
  end

  // Next-state: continue a burst, or accept a new command / cke edge
  always_comb begin
    state_s      = state_r;
    beat_s       = beat_r;
    commands_s   = 19'h0;
    bg_s         = bg_r;
    ba_s         = ba_r;
    row_s        = row_r;
    column_s     = column_r;
    burst_bank_s = burst_bank_r;
    burst_auto_s = burst_auto_r;
    bank_open_s  = open_eff_s;
    act_we_s     = 1'b0;
    err_evt_s    = 3'd0;
    if ((state_r == ST_BURST) && !last_beat_s) begin
      commands_s = commands_r;
      beat_s     = beat_r + BLW'(1);
      column_s   = {column_r[CW-1:BLW], column_r[BLW-1:0] + BLW'(1)};
      err_evt_s  = pin_cmd_s ? 3'd4 : 3'd0;
    end else begin
      state_s   = ST_IDLE;
      beat_s    = '0;
      err_evt_s = dec_err_s;
      if (dec_err_s != 3'd0) begin
        commands_s = 19'h0;
      end else if (dec_cmd_s != 19'h0) begin
        commands_s = dec_cmd_s;
        bg_s       = bg_in;
        ba_s       = ba_in;
        case (dec_cmd_s)
          C_ACT: begin
            row_s                   = addr;
            bank_open_s[bank_idx_s] = 1'b1;
            act_we_s                = 1'b1;
          end
          C_PR:  bank_open_s[bank_idx_s] = 1'b0;
          C_PRA: bank_open_s = '0;
          C_RD, C_RDA, C_WR, C_WRA: begin
            state_s      = ST_BURST;
            row_s        = bank_row_r[bank_idx_s];
            column_s     = addr[CW-1:0];
            burst_bank_s = bank_idx_s;
            burst_auto_s = addr[10];
          end
          default: row_s = row_r;
        endcase
      end else if (cke && !cke_q_r) begin
        commands_s = C_PDX;
      end else if (!cke && cke_q_r) begin
        commands_s = C_PD;
      end else begin
        commands_s = 19'h0;
      end
    end
    busy_s = (state_s == ST_BURST);
  end

  // State and output registers; halt freezes everything including cke sampling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      beat_r       <= '0;
      commands_r   <= 19'h0;
      bg_r         <= '0;
      ba_r         <= '0;
      row_r        <= '0;
      column_r     <= '0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      err_code_r   <= 3'd0;
      cke_q_r      <= 1'b1;
      bank_open_r  <= '0;
      burst_bank_r <= '0;
      burst_auto_r <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        bank_row_r[i] <= '0;
      end
    end else if (!halt) begin
      state_r      <= state_s;
      beat_r       <= beat_s;
      commands_r   <= commands_s;
      bg_r         <= bg_s;
      ba_r         <= ba_s;
      row_r        <= row_s;
      column_r     <= column_s;
      busy_r       <= busy_s;
      cke_q_r      <= cke;
      bank_open_r  <= bank_open_s;
      burst_bank_r <= burst_bank_s;
      burst_auto_r <= burst_auto_s;
      if (act_we_s) begin
        bank_row_r[bank_idx_s] <= addr;
      end
      if (!err_r && (err_evt_s != 3'd0)) begin
        err_r      <= 1'b1;
        err_code_r <= err_evt_s;
      end
    end
  end

  assign commands = commands_r;
  assign bg       = bg_r;
  assign ba       = ba_r;
  assign row      = row_r;
  assign column   = column_r;
  assign busy     = busy_r;
  assign err      = err_r;
  assign err_code = err_code_r;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Directed testbench for ddr4_cmd_decoder: inputs driven and outputs sampled on negedge.
module tb_ddr4_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset_n, halt, cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [0:0]  bg_in, ba_in;
  logic [16:0] addr;
  logic [18:0] commands;
  logic [0:0]  bg, ba;
  logic [16:0] row;
  logic [9:0]  column;
  logic        busy, err;
  logic [2:0]  err_code;
  int          checks = 0;
  int          failures = 0;

  ddr4_cmd_decoder dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .cke(cke), .cs_n(cs_n),
    .act_n(act_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .bg_in(bg_in), .ba_in(ba_in), .addr(addr),
    .commands(commands), .bg(bg), .ba(ba), .row(row), .column(column),
    .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pins_nop();
    cs_n = 1'b1; act_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
  endtask

  task automatic pins_act(input logic [0:0] g, input logic [0:0] b, input logic [16:0] a);
    cs_n = 1'b0; act_n = 1'b0; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    bg_in = g; ba_in = b; addr = a;
  endtask

  task automatic pins_cmd(input logic [2:0] rcw, input logic [0:0] g, input logic [0:0] b,
                          input logic [16:0] a);
    cs_n = 1'b0; act_n = 1'b1; {ras_n, cas_n, we_n} = rcw;
    bg_in = g; ba_in = b; addr = a;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; halt = 1'b0; cke = 1'b1;
    pins_nop(); bg_in = 1'b0; ba_in = 1'b0; addr = 17'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; halt = 1'b0; cke = 1'b1;
    pins_nop(); bg_in = 1'b0; ba_in = 1'b0; addr = 17'd0;
    @(negedge clk);
    checks++;
    if (commands !== 19'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_cmd: cmd=%h busy=%b want 00000/0", commands, busy);
    end
    checks++;
    if (err !== 1'b0 || err_code !== 3'd0) begin
      failures++; $display("FAIL reset_err: err=%b code=%0d want 0/0", err, err_code);
    end
    checks++;
    if (bg !== 1'b0 || ba !== 1'b0 || row !== 17'd0 || column !== 10'd0) begin
      failures++; $display("FAIL reset_addr: bg=%0d ba=%0d row=%0d col=%0d want 0", bg, ba, row, column);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_act();
    pins_act(1'b1, 1'b0, 17'd5);
    step();
    pins_nop();
    checks++;
    if (commands !== 19'h40000 || row !== 17'd5 || bg !== 1'b1 || ba !== 1'b0) begin
      failures++;
      $display("FAIL act: cmd=%h row=%0d bg=%0d ba=%0d want 40000/5/1/0", commands, row, bg, ba);
    end
    step();
    checks++;
    if (commands !== 19'h0) begin
      failures++; $display("FAIL act_pulse: cmd=%h want 00000", commands);
    end
  endtask

  task automatic test_read_burst();
    int exp_col[8] = '{3, 4, 5, 6, 7, 0, 1, 2};
    pins_cmd(3'b101, 1'b1, 1'b0, 17'd3);
    step();
    pins_nop();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (commands !== 19'h00020 || column !== 10'(exp_col[k]) || row !== 17'd5 || busy !== 1'b1) begin
        failures++;
        $display("FAIL rd_beat%0d: cmd=%h col=%0d row=%0d busy=%b want 00020/%0d/5/1",
                 k, commands, column, row, busy, exp_col[k]);
      end
      step();
    end
    checks++;
    if (commands !== 19'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL rd_end: cmd=%h busy=%b want 00000/0", commands, busy);
    end
  endtask

  task automatic test_wra_then_rd();
    int exp_col[8] = '{14, 15, 8, 9, 10, 11, 12, 13};
    pins_cmd(3'b100, 1'b1, 1'b0, 17'h0040E);
    step();
    pins_nop();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (commands !== 19'h00001 || column !== 10'(exp_col[k]) || busy !== 1'b1) begin
        failures++;
        $display("FAIL wra_beat%0d: cmd=%h col=%0d busy=%b want 00001/%0d/1",
                 k, commands, column, busy, exp_col[k]);
      end
      if (k == 7) pins_cmd(3'b101, 1'b1, 1'b0, 17'd3);
      step();
    end
    pins_nop();
    checks++;
    if (commands !== 19'h0 || busy !== 1'b0 || err !== 1'b1 || err_code !== 3'd1) begin
      failures++;
      $display("FAIL rd_closed: cmd=%h busy=%b err=%b code=%0d want 00000/0/1/1",
               commands, busy, err, err_code);
    end
  endtask

  task automatic test_halt();
    int exp_col[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    do_reset();
    pins_act(1'b0, 1'b0, 17'd7);
    step();
    pins_cmd(3'b101, 1'b0, 1'b0, 17'd0);
    step();
    pins_nop();
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (commands !== 19'h00020 || column !== 10'(exp_col[k]) || row !== 17'd7 || busy !== 1'b1) begin
        failures++;
        $display("FAIL halt_cyc%0d: cmd=%h col=%0d row=%0d busy=%b want 00020/%0d/7/1",
                 k, commands, column, row, busy, exp_col[k]);
      end
      if (k == 2) halt = 1'b1;
      if (k == 5) halt = 1'b0;
      step();
    end
    checks++;
    if (busy !== 1'b0 || commands !== 19'h0) begin
      failures++; $display("FAIL halt_end: busy=%b cmd=%h want 0/00000", busy, commands);
    end
  endtask

  task automatic test_busy_and_ref_errors();
    do_reset();
    pins_act(1'b0, 1'b1, 17'd9);
    step();
    pins_cmd(3'b101, 1'b0, 1'b1, 17'd0);
    step();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (commands !== 19'h00020 || column !== 10'(k) || row !== 17'd9) begin
        failures++;
        $display("FAIL busy_beat%0d: cmd=%h col=%0d row=%0d want 00020/%0d/9", k, commands, column, row, k);
      end
      if (k == 5) begin
        checks++;
        if (err !== 1'b1 || err_code !== 3'd4) begin
          failures++; $display("FAIL busy_err: err=%b code=%0d want 1/4", err, err_code);
        end
      end
      if (k == 4) pins_act(1'b1, 1'b1, 17'd1);
      else pins_nop();
      step();
    end
    do_reset();
    pins_act(1'b0, 1'b0, 17'd1);
    step();
    pins_cmd(3'b001, 1'b0, 1'b0, 17'd0);
    step();
    pins_nop();
    checks++;
    if (commands !== 19'h0 || err !== 1'b1 || err_code !== 3'd3) begin
      failures++; $display("FAIL ref_open: cmd=%h err=%b code=%0d want 00000/1/3", commands, err, err_code);
    end
    pins_cmd(3'b010, 1'b0, 1'b0, 17'h00400);
    step();
    pins_nop();
    checks++;
    if (commands !== 19'h00040) begin
      failures++; $display("FAIL pra: cmd=%h want 00040", commands);
    end
    pins_cmd(3'b001, 1'b0, 1'b0, 17'd0);
    step();
    pins_nop();
    checks++;
    if (commands !== 19'h00008 || err_code !== 3'd3) begin
      failures++; $display("FAIL ref_ok: cmd=%h code=%0d want 00008/3", commands, err_code);
    end
  endtask

  task automatic test_power_down();
    do_reset();
    pins_cmd(3'b010, 1'b1, 1'b1, 17'd0);
    step();
    pins_nop();
    checks++;
    if (commands !== 19'h00080 || err !== 1'b0) begin
      failures++; $display("FAIL pr_closed: cmd=%h err=%b want 00080/0", commands, err);
    end
    pins_cmd(3'b000, 1'b0, 1'b0, 17'd0);
    step();
    pins_nop();
    checks++;
    if (commands !== 19'h00400) begin
      failures++; $display("FAIL mrw: cmd=%h want 00400", commands);
    end
    cke = 1'b0;
    step();
    checks++;
    if (commands !== 19'h00200) begin
      failures++; $display("FAIL pd: cmd=%h want 00200", commands);
    end
    step();
    checks++;
    if (commands !== 19'h0) begin
      failures++; $display("FAIL pd_hold: cmd=%h want 00000", commands);
    end
    cke = 1'b1;
    step();
    checks++;
    if (commands !== 19'h00100) begin
      failures++; $display("FAIL pdx: cmd=%h want 00100", commands);
    end
  endtask

  task automatic test_reset_mid_burst();
    pins_act(1'b0, 1'b0, 17'd2);
    step();
    pins_cmd(3'b101, 1'b0, 1'b0, 17'd4);
    step();
    pins_nop();
    step();
    step();
    checks++;
    if (busy !== 1'b1 || column !== 10'd6) begin
      failures++; $display("FAIL pre_abort: busy=%b col=%0d want 1/6", busy, column);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (commands !== 19'h0 || busy !== 1'b0 || column !== 10'd0 || row !== 17'd0) begin
      failures++;
      $display("FAIL async_abort: cmd=%h busy=%b col=%0d row=%0d want 0", commands, busy, column, row);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_act();
    test_read_burst();
    test_wra_then_rd();
    test_halt();
    test_busy_and_ref_errors();
    test_power_down();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
